// File: rtl/count_seq_checker.sv
// Sequence monitor for a free-running up counter: tracks lock, wraps and sequence errors.
// Optional mismatch capture outputs (err_exp/err_act) are enabled by COUNT_SEQ_CHECKER_ERR_CAPTURE_EN.
module count_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int EVW      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_rst_in,
  output logic             locked,
  output logic             fault,
  output logic             err,
  output logic             wrap,
  output logic [EVW-1:0]   wrap_count,
  output logic [EVW-1:0]   err_count
`ifdef COUNT_SEQ_CHECKER_ERR_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_act
`endif
);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_LOCKED   = 2'd1;
  localparam logic [1:0] ST_FAULT    = 2'd2;

  localparam logic [3:0] LOCK_TGT = LOCK_CNT[3:0];

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] exp_reg, exp_next;
  logic             exp_valid_reg;
  logic [3:0]       match_run_reg, match_run_next;
  logic             prev_rst_reg;
  logic             err_next, wrap_next;
  logic [EVW-1:0]   wrap_count_reg, wrap_count_next;
  logic [EVW-1:0]   err_count_reg, err_count_next;
  logic             locked_reg, fault_reg, err_reg, wrap_reg;
  logic             match;
  logic [3:0]       run_inc;

  assign match   = exp_valid_reg && (cnt_in == exp_reg);
  assign run_inc = match_run_reg + 4'd1;

  // Next expectation depends only on the sampled value and the counter's reset.
  assign exp_next = cnt_rst_in ? '0 : cnt_in + WIDTH'(1);

  always_comb begin
    state_next      = state_reg;
    match_run_next  = match_run_reg;
    err_next        = 1'b0;
    wrap_next       = 1'b0;
    wrap_count_next = wrap_count_reg;
    err_count_next  = err_count_reg;
    case (state_reg)
      ST_UNLOCKED: begin
        if (match) begin
          match_run_next = run_inc;
          if (run_inc >= LOCK_TGT) begin
            state_next     = ST_LOCKED;
            match_run_next = '0;
          end
        end else begin
          match_run_next = '0;
        end
      end
      ST_LOCKED: begin
        if (!match) begin
          err_next = 1'b1;
          if (err_count_reg != {EVW{1'b1}})
            err_count_next = err_count_reg + EVW'(1);
          // A mismatch coinciding with a counter reset is reported, then the reset is honoured.
          state_next     = cnt_rst_in ? ST_UNLOCKED : ST_FAULT;
          match_run_next = '0;
        end else if ((cnt_in == '0) && !prev_rst_reg) begin
          wrap_next = 1'b1;
          if (wrap_count_reg != {EVW{1'b1}})
            wrap_count_next = wrap_count_reg + EVW'(1);
        end
      end
      ST_FAULT: begin
        match_run_next = '0;
        if (cnt_rst_in)
          state_next = ST_UNLOCKED;
      end
      default: begin
        state_next     = ST_UNLOCKED;
        match_run_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_UNLOCKED;
      exp_reg        <= '0;
      exp_valid_reg  <= 1'b0;
      match_run_reg  <= '0;
      prev_rst_reg   <= 1'b0;
      locked_reg     <= 1'b0;
      fault_reg      <= 1'b0;
      err_reg        <= 1'b0;
      wrap_reg       <= 1'b0;
      wrap_count_reg <= '0;
      err_count_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      exp_reg        <= exp_next;
      exp_valid_reg  <= 1'b1;
      match_run_reg  <= match_run_next;
      prev_rst_reg   <= cnt_rst_in;
      locked_reg     <= (state_next == ST_LOCKED);
      fault_reg      <= (state_next == ST_FAULT);
      err_reg        <= err_next;
      wrap_reg       <= wrap_next;
      wrap_count_reg <= wrap_count_next;
      err_count_reg  <= err_count_next;
    end
  end

  assign locked     = locked_reg;
  assign fault      = fault_reg;
  assign err        = err_reg;
  assign wrap       = wrap_reg;
  assign wrap_count = wrap_count_reg;
  assign err_count  = err_count_reg;

`ifdef COUNT_SEQ_CHECKER_ERR_CAPTURE_EN
  logic [WIDTH-1:0] err_exp_reg, err_act_reg;
  logic             cap_done_reg;

  // Only the first error after reset is kept, so the root cause is not overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_exp_reg  <= '0;
      err_act_reg  <= '0;
      cap_done_reg <= 1'b0;
    end else if (err_next && !cap_done_reg) begin
      err_exp_reg  <= exp_reg;
      err_act_reg  <= cnt_in;
      cap_done_reg <= 1'b1;
    end
  end

  assign err_exp = err_exp_reg;
  assign err_act = err_act_reg;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Self-checking bench for count_seq_checker: vector table plus hand sequences through a scoreboard queue.
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       cnt_rst_in;
  logic [3:0] cnt_in;
  logic       locked, fault, err, wrap;
  logic [1:0] wrap_count, err_count;
`ifdef COUNT_SEQ_CHECKER_ERR_CAPTURE_EN
  logic [3:0] err_exp, err_act;
`endif

  always #5 clk = ~clk;

  count_seq_checker #(.WIDTH(4), .LOCK_CNT(2), .EVW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .cnt_rst_in (cnt_rst_in),
    .locked     (locked),
    .fault      (fault),
    .err        (err),
    .wrap       (wrap),
    .wrap_count (wrap_count),
    .err_count  (err_count)
`ifdef COUNT_SEQ_CHECKER_ERR_CAPTURE_EN
    ,
    .err_exp    (err_exp),
    .err_act    (err_act)
`endif
  );

  typedef struct {
    logic       rst;
    logic       crst;
    logic [3:0] cnt;
    logic       locked;
    logic       fault;
    logic       err;
    logic       wrap;
    logic [1:0] wc;
    logic [1:0] ec;
  } vec_t;

  typedef struct {
    logic       locked;
    logic       fault;
    logic       err;
    logic       wrap;
    logic [1:0] wc;
    logic [1:0] ec;
    logic [3:0] ce;
    logic [3:0] ca;
  } exp_t;

  exp_t       sb_q[$];
  vec_t       tbl[6];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         n_txn = 0;
  logic [3:0] cap_e = 4'd0;
  logic [3:0] cap_a = 4'd0;
  logic [3:0] q;
  logic [1:0] wc, ec;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s txn=%0d actual=%0h required=%0h", name, n_txn, act, req);
    end
  endtask

  // Drive one sample, queue its expected result, and check it after the edge.
  task automatic step(input logic r, input logic cr, input logic [3:0] c,
                      input logic el, input logic ef, input logic ee, input logic ew,
                      input logic [1:0] ewc, input logic [1:0] eec);
    exp_t e, got;
    rst        = r;
    cnt_rst_in = cr;
    cnt_in     = c;
    e.locked = el; e.fault = ef; e.err = ee; e.wrap = ew;
    e.wc = ewc; e.ec = eec; e.ce = cap_e; e.ca = cap_a;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got = sb_q.pop_front();
    n_txn++;
    $display("txn %0d rst=%0b crst=%0b cnt=%0d -> locked=%0b fault=%0b err=%0b wrap=%0b wc=%0d ec=%0d",
             n_txn, r, cr, c, locked, fault, err, wrap, wrap_count, err_count);
    chk("locked", {7'd0, locked}, {7'd0, got.locked});
    chk("fault", {7'd0, fault}, {7'd0, got.fault});
    chk("err", {7'd0, err}, {7'd0, got.err});
    chk("wrap", {7'd0, wrap}, {7'd0, got.wrap});
    chk("wrap_count", {6'd0, wrap_count}, {6'd0, got.wc});
    chk("err_count", {6'd0, err_count}, {6'd0, got.ec});
`ifdef COUNT_SEQ_CHECKER_ERR_CAPTURE_EN
    chk("err_exp", {4'd0, err_exp}, {4'd0, got.ce});
    chk("err_act", {4'd0, err_act}, {4'd0, got.ca});
`endif
  endtask

  initial begin
    rst = 1'b1; cnt_rst_in = 1'b0; cnt_in = 4'd0;
    // Reset for two edges, then the counter counts from 0; lock after sampling q=2.
    tbl[0] = '{1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[1] = '{1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[2] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[3] = '{1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[4] = '{1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
    tbl[5] = '{1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
    @(negedge clk);
    for (int i = 0; i < 6; i++)
      step(tbl[i].rst, tbl[i].crst, tbl[i].cnt, tbl[i].locked, tbl[i].fault,
           tbl[i].err, tbl[i].wrap, tbl[i].wc, tbl[i].ec);

    // Free run of 40 samples: 4..15,0,..,15,0,..,11 gives two wraps.
    q = 4'd4; wc = 2'd0; ec = 2'd0;
    for (int i = 0; i < 40; i++) begin
      if (q == 4'd0 && wc != 2'd3) wc = wc + 2'd1;
      step(1'b0, 1'b0, q, 1'b1, 1'b0, 1'b0, (q == 4'd0), wc, ec);
      q = q + 4'd1;
    end
    chk("wraps_after_free_run", {6'd0, wrap_count}, 8'd2);

    // Continue to 5 (one more wrap, count saturates at 3), then skip 6 -> 9.
    for (int i = 0; i < 10; i++) begin
      if (q == 4'd0 && wc != 2'd3) wc = wc + 2'd1;
      step(1'b0, 1'b0, q, 1'b1, 1'b0, 1'b0, (q == 4'd0), wc, ec);
      q = q + 4'd1;
    end
    cap_e = 4'd6; cap_a = 4'd9; ec = 2'd1;
    step(1'b0, 1'b0, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0, wc, ec);
    step(1'b0, 1'b0, 4'd10, 1'b0, 1'b1, 1'b0, 1'b0, wc, ec);

    // Counter reset releases FAULT; relock after matching 0 and 1, no wrap on 0.
    step(1'b0, 1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, wc, ec);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, wc, ec);
    step(1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, wc, ec);
    for (int i = 2; i < 7; i++)
      step(1'b0, 1'b0, 4'(i), 1'b1, 1'b0, 1'b0, 1'b0, wc, ec);

    // Counter reset while locked at 7: the following 0 is legal and not a wrap.
    step(1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, wc, ec);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, wc, ec);
    step(1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, wc, ec);
    step(1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, wc, ec);

    // Counter reset held for several cycles: a stream of zeros matches.
    step(1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, wc, ec);
    step(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, wc, ec);
    step(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, wc, ec);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, wc, ec);
    step(1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, wc, ec);

    // Mismatch together with counter reset: err reported, back to UNLOCKED, capture kept.
    ec = 2'd2;
    step(1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, wc, ec);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, wc, ec);
    step(1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, wc, ec);

    // Further faults: err still pulses while err_count saturates at 3.
    for (int k = 0; k < 3; k++) begin
      if (ec != 2'd3) ec = ec + 2'd1;
      step(1'b0, 1'b0, 4'd12, 1'b0, 1'b1, 1'b1, 1'b0, wc, ec);
      step(1'b0, 1'b1, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0, wc, ec);
      step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, wc, ec);
      step(1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, wc, ec);
    end
    chk("err_count_saturated", {6'd0, err_count}, 8'd3);

    // Checker reset mid-run clears everything; relock from scratch.
    step(1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, wc, ec);
    cap_e = 4'd0; cap_a = 4'd0; wc = 2'd0; ec = 2'd0;
    step(1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, wc, ec);
    step(1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, wc, ec);
    step(1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, wc, ec);
    step(1'b0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, wc, ec);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
